// File: rtl/fifo_arbiter_pkg.sv
// fifo_arbiter_pkg: shared types and helpers for the FIFO arbiter slice.
//   arb_state_e  - arbiter FSM state (ARB = picking a port, BURST = serving owner)
//   burst_cnt_w  - burst counter width, sized for burst_len up to 16
//   port_idx_w() - bits needed to hold a port index (minimum 1)
package fifo_arbiter_pkg;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int burst_cnt_w = 5;

  function automatic int port_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_arbiter_if.sv
// fifo_arbiter_if: request/response bundle between requesters, consumer and the
// arbiter.
//   req_valid/req_data/req_ready - per-port offer and one-hot grant
//   out_valid/out_data/out_port  - head of the buffer and its source port
//   out_ready                    - consumer pop
//   full                         - buffer holds its maximum number of words
// master = the environment (requesters + consumer), slave = the arbiter.
interface fifo_arbiter_if
  import fifo_arbiter_pkg::*;
#(
  parameter int data_width = 32,
  parameter int num_ports  = 4
);
  localparam int port_w = port_idx_w(num_ports);

  logic [num_ports-1:0]            req_valid;
  logic [num_ports*data_width-1:0] req_data;
  logic [num_ports-1:0]            req_ready;
  logic                            out_valid;
  logic [data_width-1:0]           out_data;
  logic [port_w-1:0]               out_port;
  logic                            out_ready;
  logic                            full;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_port, full
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_port, full
  );
endinterface

// File: rtl/fifo_arbiter_tagged_fifo.sv
// tagged_fifo: circular buffer of 2**depth_bits words, each word {port, data}.
//   clk/reset_n - clock, asynchronous active-low reset (pointers and count only)
//   push/push_data - write, ignored while full
//   pop            - read, ignored while empty
//   head_data      - entry at the read pointer (combinational, no bypass)
//   not_empty/full - occupancy flags derived from the registered count
module tagged_fifo #(
  parameter int width      = 8,
  parameter int depth_bits = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head_data,
  output logic             not_empty,
  output logic             full
);
  localparam int depth = 1 << depth_bits;
  localparam logic [depth_bits:0] full_cnt = {1'b1, {depth_bits{1'b0}}};

  logic [width-1:0]      mem_q [depth];
  logic [depth_bits-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [depth_bits:0]   count_q, count_d;
  logic                  do_push, do_pop;

  // Next pointer/count; pointers wrap naturally at 2**depth_bits.
  always_comb begin
    do_push  = push && (count_q != full_cnt);
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? (wr_ptr_q + depth_bits'(1)) : wr_ptr_q;
    rd_ptr_d = do_pop  ? (rd_ptr_q + depth_bits'(1)) : rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (depth_bits+1)'(1);
      2'b01:   count_d = count_q - (depth_bits+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless once the count says so.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign not_empty = (count_q != '0);
  assign full      = (count_q == full_cnt);
endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: round-robin, burst-capable arbiter feeding a tagged FIFO.
//   clk     - single clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - fifo_arbiter_if slave: requester handshake, buffer head, full
// In ARB the first valid port at or after ptr is granted in the same cycle; with
// burst_len > 1 the winner then owns the grant in BURST until it has sent
// burst_len beats or drops valid, after which one idle cycle returns to ARB.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int data_width = 32,
  parameter int num_ports  = 4,
  parameter int depth_bits = 4,
  parameter int burst_len  = 4
) (
  input logic           clk,
  input logic           reset_n,
  fifo_arbiter_if.slave bus
);
  localparam int port_w = port_idx_w(num_ports);
  localparam logic [burst_cnt_w-1:0] burst_max = burst_cnt_w'(burst_len);

  arb_state_e              state_q, state_d;
  logic [port_w-1:0]       ptr_q, ptr_d, owner_q, owner_d;
  logic [burst_cnt_w-1:0]  cnt_q, cnt_d;
  logic [num_ports-1:0]    grant;
  logic                    found;
  logic [port_w-1:0]       cand, push_port;
  logic [data_width-1:0]   push_data;
  logic                    fifo_full;
  logic [port_w+data_width-1:0] head;
  int                      idx;

  // Arbitration, burst bookkeeping and write-side mux.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    grant     = '0;
    found     = 1'b0;
    cand      = '0;
    idx       = 0;
    push_data = '0;
    // Rotating search starting at ptr; first hit wins.
    for (int i = 0; i < num_ports; i++) begin
      idx = (int'(ptr_q) + i) % num_ports;
      if (!found && bus.req_valid[port_w'(idx)]) begin
        found = 1'b1;
        cand  = port_w'(idx);
      end else begin
        found = found;
      end
    end
    case (state_q)
      ARB: begin
        // reset_n gates the grant so nothing is offered while reset is held.
        if (reset_n && !fifo_full && found) begin
          grant[cand] = 1'b1;
          ptr_d   = (cand == port_w'(num_ports - 1)) ? '0 : (cand + port_w'(1));
          owner_d = cand;
          cnt_d   = burst_cnt_w'(1);
          state_d = (burst_len > 1) ? BURST : ARB;
        end else begin
          state_d = ARB;
        end
      end
      BURST: begin
        if (cnt_q >= burst_max) begin
          state_d = ARB;            // burst exhausted: idle cycle, no grant
        end else if (fifo_full) begin
          state_d = BURST;          // stall with owner and count held
        end else if (bus.req_valid[owner_q]) begin
          grant[owner_q] = 1'b1;
          cnt_d = cnt_q + burst_cnt_w'(1);
        end else begin
          state_d = ARB;            // owner went quiet
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
    push_port = (state_q == BURST) ? owner_q : cand;
    for (int i = 0; i < num_ports; i++) begin
      if (push_port == port_w'(i)) begin
        push_data = bus.req_data[i*data_width +: data_width];
      end else begin
        push_data = push_data;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  tagged_fifo #(
    .width      (port_w + data_width),
    .depth_bits (depth_bits)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (|grant),
    .push_data ({push_port, push_data}),
    .pop       (bus.out_ready),
    .head_data (head),
    .not_empty (bus.out_valid),
    .full      (fifo_full)
  );

  assign bus.req_ready = grant;
  assign bus.full      = fifo_full;
  assign {bus.out_port, bus.out_data} = head;
endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 SHALL have parameter data_width, default 32, meaning payload bits per word.
REQ-002 SHALL have parameter num_ports, default 4, meaning requester count (2..8).
REQ-003 SHALL have parameter depth_bits, default 4, meaning log2 of buffer depth.
REQ-004 SHALL have parameter burst_len, default 4, meaning max consecutive beats per grant (1..16).
REQ-005 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  num_ports  per-port word offered.
REQ-008 SHALL have port req_data  input  num_ports*data_width  port i payload in bits [i*data_width +: data_width].
REQ-009 SHALL have port req_ready  output  num_ports  one-hot (or zero) grant; word accepted when valid&ready.
REQ-010 SHALL have port out_valid  output  1  buffer non-empty.
REQ-011 SHALL have port out_data  output  data_width  head-of-buffer payload.
REQ-012 SHALL have port out_port  output  clog2(num_ports)  source port index of head word.
REQ-013 SHALL have port out_ready  input  1  consumer pops head when out_valid&out_ready.
REQ-014 SHALL have port full  output  1  buffer holds 2**depth_bits words.

Function
REQ-015 SHALL keep state ARB or BURST; reset state ARB.
REQ-016 In ARB, SHALL grant, combinationally in the same cycle, the first valid port at or after priority pointer ptr (mod num_ports), only if !full.
REQ-017 On an ARB grant to port g, SHALL set ptr to (g+1) mod num_ports, load burst counter with 1, and enter BURST if burst_len>1.
REQ-018 In BURST, SHALL assert req_ready only to the owner port g, only while req_valid[g] and !full.
REQ-019 In BURST, each accepted beat SHALL increment the burst counter; on reaching burst_len, or when req_valid[g] is low, SHALL return to ARB with no grant that cycle.
REQ-020 In BURST, full SHALL stall the burst (counter and owner held, no return to ARB).
REQ-021 With no valid port in ARB, SHALL leave ptr unchanged and req_ready all zero.
REQ-022 An accepted word SHALL be written with its port index into the buffer; out_valid SHALL rise in the following cycle (1-cycle write-to-read latency, no bypass).
REQ-023 out_data/out_port SHALL reflect the head entry combinationally from read pointer.
REQ-024 Pop and push in the same cycle SHALL both take effect; count unchanged.
REQ-025 When full, req_ready SHALL be 0 even if a pop occurs that cycle (no full-pass-through).
REQ-026 Pointers SHALL wrap modulo 2**depth_bits; count SHALL be depth_bits+1 bits, never exceeding depth nor going below 0.
REQ-027 req_valid dropped without handshake SHALL be legal; req_data is sampled only at handshake.

Reset
REQ-028 Asserting reset_n low SHALL immediately clear state to ARB, ptr to 0, burst counter to 0, buffer pointers and count to 0.
REQ-029 During and after reset: req_ready=0, out_valid=0, full=0; buffer contents are don't-care and discarded mid-burst.
REQ-030 Deassertion SHALL be synchronized externally; first grant possible on first edge after release.

Structure
REQ-031 Package fifo_arbiter_pkg SHALL hold the state enum (ARB, BURST) and port-index width function.
REQ-032 Buffer SHALL be sub-module tagged_fifo (async reset, stores {port, data}); arbiter FSM in top level.

Verification
REQ-033 After reset, ports 0..3 valid constantly, burst_len=1, out_ready=1 -> grants 0,1,2,3,0 in consecutive cycles; out_port same order one cycle later.
REQ-034 burst_len=4, port 2 valid 6 beats, port 0 valid -> port 2 gets 4 beats, ARB idle cycle, port 0 granted, then port 2 resumes.
REQ-035 out_ready=0, port 1 pushes 16 words (depth_bits=4) -> full=1 after 16th, req_ready=0; one pop -> req_ready reasserts next cycle.
REQ-036 Count=5, simultaneous push and pop for 20 cycles -> count stays 5, pointers wrap, data order 0..19 preserved.
REQ-037 reset_n low mid-burst with 3 entries -> out_valid=0, req_ready=0 immediately; after release port 0 granted first.
